// File: rtl/axis_variable_sched_if.sv
// axis_variable_sched_if: AXI-Stream master bus carrying one variable value tagged with its channel index
interface axis_variable_sched_if #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int DEST_WIDTH = 4
);
  logic [AXIS_TDATA_WIDTH-1:0] tdata;
  logic [DEST_WIDTH-1:0] tdest;
  logic tvalid;
  logic tready;
  modport master (output tdata, tdest, tvalid, input tready);
  modport slave (input tdata, tdest, tvalid, output tready);
endinterface

// File: rtl/axis_variable_sched.sv
// axis_variable_sched: reports changed (or refreshed) channel values over one AXIS master, round-robin
module axis_variable_sched #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int NUM_CH = 4,
  parameter int DEST_WIDTH = 4
) (
  input  logic m_axis_aclk,
  input  logic m_axis_areset,
  input  logic [NUM_CH*AXIS_TDATA_WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic refresh,
  axis_variable_sched_if.master m_axis,
  output logic busy
);
  localparam int W = AXIS_TDATA_WIDTH;
  localparam int CW = $clog2(NUM_CH);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic [W-1:0] shadow_q [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d, set_v, done_v;
  logic [CW-1:0] last_q, grant, idx;
  logic [W-1:0] tdata_q;
  logic [DEST_WIDTH-1:0] tdest_q;
  logic free, hit, take;
  // Round-robin pick among pending channels, searching from the one after the last grant
  always_comb begin
    grant = last_q;
    hit = 1'b0;
    idx = last_q;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CW'((int'(last_q) + k) % NUM_CH);
      if (!hit && pend_q[idx]) begin
        grant = idx;
        hit = 1'b1;
      end
    end
  end
  // Pend bookkeeping: a fresh change or refresh outranks the clear caused by this cycle's grant
  always_comb begin
    free = !m_axis.tvalid || m_axis.tready;
    take = free && hit;
    done_v = take ? ({{(NUM_CH-1){1'b0}}, 1'b1} << grant) : '0;
    for (int i = 0; i < NUM_CH; i++)
      set_v[i] = ch_enable[i] && ((data_in[i*W +: W] != shadow_q[i]) || refresh);
    pend_d = ch_enable & (set_v | (pend_q & ~done_v));
    state_d = free ? (hit ? FULL : EMPTY) : state_q;
  end
  // Output slot FSM with shadows, pend bits and registered beat contents
  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      state_q <= EMPTY;
      pend_q <= '0;
      last_q <= CW'(NUM_CH - 1);
      tdata_q <= '0;
      tdest_q <= '0;
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= data_in[i*W +: W];
      if (take) begin
        tdata_q <= shadow_q[grant];
        tdest_q <= DEST_WIDTH'(grant);
        last_q <= grant;
      end
    end
  end
  assign m_axis.tvalid = (state_q == FULL);
  assign m_axis.tdata = tdata_q;
  assign m_axis.tdest = tdest_q;
  assign busy = (|pend_q) || (state_q == FULL);
endmodule

// File: doc/axis_variable_sched.md
AXIS_VARIABLE_SCHED -- requirements
Module: axis_variable_sched

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32, meaning the width of each variable and of m_axis_tdata.
REQ-002 SHALL have parameter NUM_CH, default 4, legal range 2..16, meaning the number of variable channels sharing one AXIS master.
REQ-003 SHALL have parameter DEST_WIDTH, default 4, meaning the m_axis_tdest width; it must satisfy 2^DEST_WIDTH >= NUM_CH.
REQ-004 SHALL have port m_axis_aclk  input  1  -- the single clock; all logic is on its rising edge.
REQ-005 SHALL have port m_axis_areset  input  1  -- reset, synchronous, active-high.
REQ-006 SHALL have port data_in  input  NUM_CH*AXIS_TDATA_WIDTH  -- channel i in bits [i*W +: W].
REQ-007 SHALL have port ch_enable  input  NUM_CH  -- per-channel enable for change reporting.
REQ-008 SHALL have port refresh  input  1  -- single-cycle request to resend all enabled channels.
REQ-009 SHALL have port m_axis_tready  input  1  -- downstream ready.
REQ-010 SHALL have port m_axis_tdata  output  AXIS_TDATA_WIDTH  -- value of the granted channel.
REQ-011 SHALL have port m_axis_tdest  output  DEST_WIDTH  -- index of the granted channel, zero-extended.
REQ-012 SHALL have port m_axis_tvalid  output  1  -- output slot holds a beat.
REQ-013 SHALL have port busy  output  1  -- high when any pend bit is set or m_axis_tvalid is high.

Function
REQ-014 SHALL keep a shadow register per channel, loaded with its data_in slice on every clock edge.
REQ-015 SHALL keep a pend bit per channel; at an edge, pend[i] SHALL be set if ch_enable[i] and either (data_in[i] != shadow[i]) or refresh.
REQ-016 SHALL clear pend[i] at the edge where channel i is loaded into the output slot, unless the REQ-015 set condition is true that same cycle, in which case set wins.
REQ-017 SHALL clear pend[i] whenever ch_enable[i] is low, and SHALL never set it while ch_enable[i] is low.
REQ-018 SHALL treat the output slot as free when m_axis_tvalid is low, or when m_axis_tvalid and m_axis_tready are both high in that cycle; back-to-back beats at one per cycle are required.
REQ-019 SHALL, when the slot is free and any pend bit is set, grant one channel by round-robin.
  - Search starts at last_grant+1 and wraps from NUM_CH-1 to 0.
  - At that edge: load m_axis_tdata with shadow[grant] and m_axis_tdest with grant, set m_axis_tvalid, and update last_grant.
REQ-020 SHALL, when the slot is free and no pend bit is set, deassert m_axis_tvalid at that edge.
REQ-021 SHALL hold m_axis_tdata, m_axis_tdest and m_axis_tvalid stable while m_axis_tvalid is high and m_axis_tready is low.
  - This holds even if the granted channel's data_in changes or its ch_enable drops.
  - No retraction of a presented beat.
REQ-022 SHALL have a latency of 2 edges: a data_in change present before edge E0 sets pend at E0, and tvalid with the new value is visible after E1 when the slot is free and the channel wins.
REQ-023 SHALL report only the latest value: multiple changes while pending produce one beat carrying the value at grant time.
REQ-024 SHALL treat a change of the channel currently in the slot as a new pend, producing a later additional beat.
REQ-025 SHALL guarantee that no enabled pending channel waits more than NUM_CH grants.
REQ-026 SHALL act as a two-state output FSM: EMPTY (tvalid=0) and FULL (tvalid=1).
  - EMPTY->FULL: any pend set.
  - FULL->FULL: handshake with pend set, or no handshake.
  - FULL->EMPTY: handshake with no pend set.

Reset
REQ-027 SHALL, on m_axis_areset high at an edge, clear shadows, pend, m_axis_tdata, m_axis_tdest and m_axis_tvalid to 0, and set last_grant to NUM_CH-1, so channel 0 has first priority.
REQ-028 SHALL abort a beat in flight on reset mid-transfer: tvalid=0 after the reset edge, and that beat is not resent unless data_in still differs from the new zero shadow.
REQ-029 SHALL, on the first edge after reset releases, set pend for every enabled channel whose data_in is nonzero.

Verification
REQ-030 Single change: NUM_CH=4, tready=1, ch2 goes 0->0x1234 -> one beat tdata=0x1234, tdest=2, tvalid high exactly 1 cycle, 2 edges after the change.
REQ-031 Round-robin: ch0..ch3 change in the same cycle, tready=1 -> beats with tdest 0,1,2,3 on consecutive cycles; repeat after last_grant=1 -> order 2,3,0,1.
REQ-032 Backpressure: tready=0 for 10 cycles with ch1 beat presented while ch1 changes 5->6->7 -> tdata stays 5; after accept, one further beat tdata=7, tdest=1.
REQ-033 Enable/refresh: ch_enable=4'b0101, refresh pulse -> beats for ch0 and ch2 only; a change on ch1 -> no beat; drop ch_enable[2] while ch2 is pending -> ch2 beat never issued.
REQ-034 Reset mid-transfer: reset asserted while tvalid=1, tready=0 -> tvalid=0, busy=0 after the reset edge; data_in[0]=0xA after release -> beat 0xA, tdest=0.
REQ-035 Sustained toggle: ch3 toggles every cycle, others static, tready=1 -> tvalid stays high continuously and no other channel is starved when it later changes.
